// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the fetch PC, requests one line at a time when the
// ibuffer has room for it, forwards the returned line and flushes on redirects.
module fetch_sequencer #(
    parameter logic [47:0] RESET_PC   = 48'h0,
    parameter int          IBUF_DEPTH = 24,
    parameter int          LINE_INSTS = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fetch_enable,
    input  logic                     redirect_valid,
    input  logic [47:0]              redirect_target,
    input  logic [4:0]               ibuf_count,
    output logic                     mem_req_valid,
    output logic [47:0]              mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [LINE_INSTS*32-1:0] mem_resp_data,
    output logic                     ibuf_line_valid,
    output logic [LINE_INSTS*32-1:0] ibuf_line_data,
    output logic [47:0]              ibuf_line_pc,
    output logic                     ibuf_clear,
    output logic [47:0]              fetch_pc,
    output logic [31:0]              lines_fetched
);

    localparam int          LINE_BITS  = LINE_INSTS * 32;
    localparam int          FILL_W     = $clog2(LINE_INSTS + 1);
    localparam int          CREDIT_MAX = IBUF_DEPTH - LINE_INSTS;
    localparam logic [47:0] PC_STEP    = 48'(LINE_INSTS * 4);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;

    state_e              state_q, state_d;
    logic [47:0]         pc_q, pc_d;
    logic                drop_q, drop_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [31:0]         lines_q, lines_d;
    logic                req_valid_q, req_valid_d;
    logic                line_valid_q, line_valid_d;
    logic                clear_q, clear_d;
    logic [LINE_BITS-1:0] line_data_q;
    logic [47:0]         line_pc_q;
    logic                capture;
    logic                credit_ok;

    assign credit_ok = (int'(ibuf_count) <= CREDIT_MAX);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        fill_d       = fill_q;
        lines_d      = lines_q;
        line_valid_d = 1'b0;
        clear_d      = 1'b0;
        capture      = 1'b0;

        if (redirect_valid) begin
            pc_d    = redirect_target;
            clear_d = 1'b1;
            fill_d  = '0;
            unique case (state_q)
                REQ: begin
                    // An accepted request is already in flight; its response must be dropped.
                    if (mem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: if (fetch_enable && credit_ok) state_d = REQ;
                REQ:  if (mem_req_ready) state_d = WAIT;
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            capture      = 1'b1;
                            line_valid_d = 1'b1;
                            pc_d         = pc_q + PC_STEP;
                            lines_d      = lines_q + 32'd1;
                            fill_d       = FILL_W'(LINE_INSTS);
                            state_d      = FILL;
                        end
                    end
                end
                FILL: begin
                    fill_d = fill_q - FILL_W'(1);
                    if (fill_q <= FILL_W'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        req_valid_d = (state_d == REQ);
    end

    // NOTE: sequential state uses non-blocking assignments; the wide line register is
    // reset as well because its reset value is architecturally visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            fill_q       <= '0;
            lines_q      <= '0;
            req_valid_q  <= 1'b0;
            line_valid_q <= 1'b0;
            clear_q      <= 1'b0;
            line_data_q  <= '0;
            line_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            fill_q       <= fill_d;
            lines_q      <= lines_d;
            req_valid_q  <= req_valid_d;
            line_valid_q <= line_valid_d;
            clear_q      <= clear_d;
            if (capture) begin
                line_data_q <= mem_resp_data;
                line_pc_q   <= pc_q;
            end
        end
    end

    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = pc_q;
    assign fetch_pc        = pc_q;
    assign ibuf_line_valid = line_valid_q;
    assign ibuf_line_data  = line_data_q;
    assign ibuf_line_pc    = line_pc_q;
    assign ibuf_clear      = clear_q;
    assign lines_fetched   = lines_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written redirect/wrap/reset
// sequences, then random traffic against a flag-based behavioural model.
module tb_fetch_sequencer;

    localparam logic [47:0] RESET_PC = 48'h0;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         fetch_enable;
    logic         redirect_valid;
    logic [47:0]  redirect_target;
    logic [4:0]   ibuf_count;
    logic         mem_req_valid;
    logic [47:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;
    logic         ibuf_line_valid;
    logic [511:0] ibuf_line_data;
    logic [47:0]  ibuf_line_pc;
    logic         ibuf_clear;
    logic [47:0]  fetch_pc;
    logic [31:0]  lines_fetched;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(.RESET_PC(RESET_PC), .IBUF_DEPTH(24), .LINE_INSTS(16)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_enable    (fetch_enable),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ibuf_count      (ibuf_count),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .ibuf_line_valid (ibuf_line_valid),
        .ibuf_line_data  (ibuf_line_data),
        .ibuf_line_pc    (ibuf_line_pc),
        .ibuf_clear      (ibuf_clear),
        .fetch_pc        (fetch_pc),
        .lines_fetched   (lines_fetched)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {req_valid, req_addr, line_valid, clear, fetch_pc, lines_fetched, line_pc}
    function automatic logic [178:0] outs();
        return {mem_req_valid, mem_req_addr, ibuf_line_valid, ibuf_clear,
                fetch_pc, lines_fetched, ibuf_line_pc};
    endfunction

    function automatic logic [511:0] pattern(input int i);
        logic [511:0] p;
        for (int w = 0; w < 16; w++) p[w*32 +: 32] = (32'(i) * 32'h0101_0101) ^ 32'hDEAD_0000 ^ 32'(w);
        return p;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] p;
        for (int w = 0; w < 16; w++) p[w*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic idle_inputs();
        fetch_enable    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        ibuf_count      = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_data   = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [178:0] reset_outs();
        return {1'b0, RESET_PC, 1'b0, 1'b0, RESET_PC, 32'd0, 48'd0};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fe;
        logic [4:0]  cnt;
        logic        rdy;
        logic        rsp;
        logic        exp_req;
        logic [47:0] exp_addr;
        logic        exp_lv;
        logic [31:0] exp_lines;
        logic [47:0] exp_lpc;
    } vec_t;

    function automatic vec_t mk(input logic fe, input int cnt, input logic rdy, input logic rsp,
                                input logic req, input logic [47:0] addr, input logic lv,
                                input int lines, input logic [47:0] lpc);
        vec_t v;
        v.fe = fe; v.cnt = 5'(cnt); v.rdy = rdy; v.rsp = rsp;
        v.exp_req = req; v.exp_addr = addr; v.exp_lv = lv;
        v.exp_lines = 32'(lines); v.exp_lpc = lpc;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic         m_req, m_flight, m_stale, m_lv, m_clr;
    int           m_hold;
    logic [47:0]  m_pc, m_lpc;
    logic [31:0]  m_lines;
    logic [511:0] m_data;

    task automatic model_reset();
        m_req = 0; m_flight = 0; m_stale = 0; m_lv = 0; m_clr = 0; m_hold = 0;
        m_pc = RESET_PC; m_lpc = '0; m_lines = '0; m_data = '0;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        m_lv  = 0;
        m_clr = redirect_valid;
        if (redirect_valid) begin
            m_pc   = redirect_target;
            m_hold = 0;
            if (m_req) begin
                m_req = 0;
                if (mem_req_ready) begin m_flight = 1; m_stale = 1; end
            end else if (m_flight) begin
                if (mem_resp_valid) begin m_flight = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else if (m_req) begin
            if (mem_req_ready) begin m_req = 0; m_flight = 1; end
        end else if (m_flight) begin
            if (mem_resp_valid) begin
                m_flight = 0;
                if (m_stale) m_stale = 0;
                else begin
                    m_data  = mem_resp_data;
                    m_lpc   = m_pc;
                    m_pc    = m_pc + 48'd64;
                    m_lines = m_lines + 1;
                    m_lv    = 1;
                    m_hold  = 16;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (fetch_enable && int'(ibuf_count) <= 24 - 16) begin
            m_req = 1;
        end
    endtask

    initial begin
        vec_t vecs[28];
        logic [47:0] t;

        vecs[0] = mk(1, 0, 1, 1, 1, 48'd0, 0, 0, 48'd0);    // response in IDLE is ignored
        vecs[1] = mk(1, 0, 1, 0, 0, 48'd0, 0, 0, 48'd0);
        vecs[2] = mk(1, 0, 0, 0, 0, 48'd0, 0, 0, 48'd0);
        vecs[3] = mk(1, 0, 0, 1, 0, 48'd64, 1, 1, 48'd0);
        for (int i = 4; i < 20; i++) vecs[i] = mk(1, 9, 0, (i == 5), 0, 48'd64, 0, 1, 48'd0);
        for (int i = 20; i < 23; i++) vecs[i] = mk(1, 9, 1, 0, 0, 48'd64, 0, 1, 48'd0);
        vecs[23] = mk(1, 8, 0, 0, 1, 48'd64, 0, 1, 48'd0);
        vecs[24] = mk(1, 8, 0, 0, 1, 48'd64, 0, 1, 48'd0);
        vecs[25] = mk(0, 8, 0, 0, 1, 48'd64, 0, 1, 48'd0);  // fetch_enable drop keeps request
        vecs[26] = mk(0, 8, 1, 0, 0, 48'd64, 0, 1, 48'd0);
        vecs[27] = mk(0, 8, 0, 1, 0, 48'd128, 1, 2, 48'd64);

        reset_n = 1'b0;
        idle_inputs();
        #12;
        check("reset_outputs", 512'(outs()), 512'(reset_outs()));
        check("reset_line_data", ibuf_line_data, '0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            fetch_enable   = vecs[i].fe;
            ibuf_count     = vecs[i].cnt;
            mem_req_ready  = vecs[i].rdy;
            mem_resp_valid = vecs[i].rsp;
            mem_resp_data  = pattern(i);
            tick();
            check($sformatf("vec[%0d]", i), 512'(outs()),
                  512'({vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_lv, 1'b0,
                        vecs[i].exp_addr, vecs[i].exp_lines, vecs[i].exp_lpc}));
            if (vecs[i].exp_lv) check($sformatf("vec[%0d]_data", i), ibuf_line_data, pattern(i));
        end

        // Redirect while waiting for a response: response dropped, next request to target.
        do_reset();
        fetch_enable = 1; mem_req_ready = 1;
        tick(); tick();
        mem_req_ready = 0; redirect_valid = 1; redirect_target = 48'h1000;
        tick();
        check("wait_redir_clear", ibuf_clear, 1);
        check("wait_redir_pc", fetch_pc, 48'h1000);
        redirect_valid = 0;
        tick();
        check("wait_redir_clear_off", ibuf_clear, 0);
        mem_resp_valid = 1; mem_resp_data = pattern(99);
        tick();
        mem_resp_valid = 0;
        check("wait_redir_no_line", ibuf_line_valid, 0);
        check("wait_redir_lines", lines_fetched, 0);
        tick();
        check("wait_redir_req", {mem_req_valid, mem_req_addr}, {1'b1, 48'h1000});

        // Redirect on the same edge the request is accepted.
        do_reset();
        t = 48'h0000_1234_5670;
        fetch_enable = 1;
        tick();
        mem_req_ready = 1; redirect_valid = 1; redirect_target = t;
        tick();
        check("acc_redir", {mem_req_valid, ibuf_clear, fetch_pc}, {1'b0, 1'b1, t});
        redirect_valid = 0; mem_req_ready = 0;
        tick();
        check("acc_redir_waiting", {mem_req_valid, ibuf_clear}, 2'b00);
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        check("acc_redir_dropped", {ibuf_line_valid, lines_fetched}, 33'd0);
        tick();
        check("acc_redir_req", {mem_req_valid, mem_req_addr}, {1'b1, t});

        // Request stalled five cycles, then back-to-back redirects withdraw it.
        do_reset();
        t = 48'hBEEF_0000_0040;
        fetch_enable = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall[%0d]", i), {mem_req_valid, mem_req_addr}, {1'b1, 48'h0});
        end
        redirect_valid = 1; redirect_target = 48'hAAA0;
        tick();
        check("b2b_first", {mem_req_valid, ibuf_clear, fetch_pc}, {1'b0, 1'b1, 48'hAAA0});
        redirect_target = t;
        tick();
        check("b2b_second", {mem_req_valid, ibuf_clear, fetch_pc}, {1'b0, 1'b1, t});
        redirect_valid = 0;
        tick();
        check("b2b_new_req", {mem_req_valid, ibuf_clear, mem_req_addr}, {1'b1, 1'b0, t});
        tick();
        check("b2b_req_stable", {mem_req_valid, mem_req_addr}, {1'b1, t});

        // PC wrap at the top of the address space, then async reset during FILL.
        do_reset();
        redirect_valid = 1; redirect_target = 48'hFFFF_FFFF_FFC0;
        tick();
        redirect_valid = 0; fetch_enable = 1; mem_req_ready = 1;
        tick(); tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = pattern(7);
        tick();
        mem_resp_valid = 0;
        check("wrap_line", {ibuf_line_valid, ibuf_line_pc, fetch_pc, lines_fetched},
              {1'b1, 48'hFFFF_FFFF_FFC0, 48'h0, 32'd1});
        check("wrap_data", ibuf_line_data, pattern(7));
        tick(); tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("fill_async_reset", 512'(outs()), 512'(reset_outs()));
        check("fill_async_reset_data", ibuf_line_data, '0);
        @(negedge clock);
        reset_n = 1'b1;
        idle_inputs();

        // Random traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            fetch_enable    = ($urandom_range(0, 7) != 0);
            redirect_valid  = ($urandom_range(0, 24) == 0);
            redirect_target = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFC;
            ibuf_count      = 5'($urandom_range(0, 12));
            mem_req_ready   = $urandom_range(0, 1) == 1;
            mem_resp_valid  = ($urandom_range(0, 2) == 0);
            mem_resp_data   = rand_line();
            model_step();
            tick();
            check($sformatf("rand[%0d]", c), 512'(outs()),
                  512'({m_req, m_pc, m_lv, m_clr, m_pc, m_lines, m_lpc}));
            if (m_lv) check($sformatf("rand[%0d]_data", c), ibuf_line_data, m_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end fetch controller that owns the fetch PC and sequences line fetches from the memory arbiter into the instruction buffer.
- One request outstanding at a time. It issues a 16-instruction (512-bit) line request only when the instruction buffer has room for a whole line.
- It delivers the returned line to the ibuffer as a one-cycle pulse plus data and PC, and handles redirects by clearing the ibuffer and dropping stale responses.

Parameters:
- RESET_PC, 48'h0, fetch PC after reset; must be 4-byte aligned.
- IBUF_DEPTH, 24, ibuffer FIFO capacity in instructions.
- LINE_INSTS, 16, instructions per line; the line is 512 bits and the PC step is LINE_INSTS*4 = 64 bytes.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- fetch_enable  in  1  fetch permitted (backend not stalled)
- redirect_valid  in  1  branch/exception redirect pulse
- redirect_target  in  48  new fetch PC; 4-byte aligned
- ibuf_count  in  5  current ibuffer FIFO occupancy
- mem_req_valid  out  1  line request valid
- mem_req_addr  out  48  request address (= fetch_pc)
- mem_req_ready  in  1  arbiter accepts request
- mem_resp_valid  in  1  response pulse (one cycle)
- mem_resp_data  in  512  16 instructions; instruction i is in bits [32i+31:32i]
- ibuf_line_valid  out  1  line-delivered pulse to ibuffer
- ibuf_line_data  out  512  registered copy of mem_resp_data
- ibuf_line_pc  out  48  PC of instruction 0 of delivered line
- ibuf_clear  out  1  ibuffer clear pulse
- fetch_pc  out  48  current fetch PC
- lines_fetched  out  32  count of delivered (non-dropped) lines; wraps

Behaviour:
- Reset (async, reset_n=0), mid-operation included:
  - state=IDLE, fetch_pc=RESET_PC, drop=0, fill_cnt=0, lines_fetched=0.
  - All outputs 0 except fetch_pc and mem_req_addr, which equal RESET_PC.
- All outputs are registered. mem_req_addr equals fetch_pc.
- States are IDLE, REQ, WAIT and FILL.
- IDLE:
  - Go to REQ when fetch_enable=1, ibuf_count <= IBUF_DEPTH-LINE_INSTS (i.e. <= 8) and redirect_valid=0.
  - mem_req_valid rises in the cycle after the transition.
- REQ:
  - mem_req_valid=1 and mem_req_addr is held stable until accepted.
  - On the accepting edge (mem_req_valid && mem_req_ready), go to WAIT.
  - fetch_enable dropping does not withdraw the request.
- WAIT:
  - On mem_resp_valid with drop=0: capture data into ibuf_line_data and ibuf_line_pc=fetch_pc.
  - Next cycle: ibuf_line_valid=1 for exactly one cycle, fetch_pc += 64 (mod 2^48), lines_fetched += 1, fill_cnt=LINE_INSTS, go to FILL.
  - On mem_resp_valid with drop=1: discard the response, drop<=0, go to IDLE; no ibuf_line_valid.
- FILL:
  - Decrement fill_cnt each cycle; go to IDLE when it reaches 1, giving 16 cycles of FILL.
  - This covers the ibuffer's 16-cycle drain into its FIFO so that ibuf_count is settled before the next credit check.
- mem_resp_valid outside WAIT is ignored.
- Redirect (redirect_valid=1) has priority over every other event in the same cycle:
  - fetch_pc <= redirect_target, and ibuf_clear=1 in the next cycle for one cycle.
  - IDLE or FILL: go to IDLE; a FILL in progress is abandoned.
  - REQ, not accepted this cycle: withdraw; mem_req_valid=0 next cycle, go to IDLE.
  - REQ, accepted this same cycle: go to WAIT with drop=1.
  - WAIT: drop<=1 and stay in WAIT. A response arriving in the same cycle is discarded and the state goes to IDLE with drop=0.
  - WAIT with drop already 1: update fetch_pc only; drop stays 1.
  - Back-to-back redirects: the last target wins, and ibuf_clear asserts in each following cycle.
- A redirect never produces ibuf_line_valid for a line requested before it.
- Minimum request interval with ready=1 and immediate response is IDLE, REQ, WAIT(resp), FILL x16.

Test Plan:
- Reset, then fetch_enable=1, ibuf_count=0, mem_req_ready=1, response 2 cycles later -> mem_req_addr=0; ibuf_line_valid one pulse with ibuf_line_pc=0; fetch_pc=64; lines_fetched=1; second request at addr 64 after 16 FILL cycles.
- ibuf_count=9 -> no mem_req_valid. ibuf_count drops to 8 -> request issued next cycle.
- Redirect to 48'h1000 while in WAIT, then response arrives -> ibuf_clear pulse; no ibuf_line_valid; next request addr=0x1000; lines_fetched unchanged.
- Redirect in the same cycle as mem_req_ready in REQ -> WAIT with drop; response discarded; next request addr=redirect_target.
- mem_req_ready held 0 for 5 cycles, then redirect -> mem_req_valid deasserts the following cycle; new request to the target with stable address.
- fetch_pc=48'hFFFF_FFFF_FFC0 delivered -> fetch_pc wraps to 0. Assert reset_n low during FILL -> all outputs return to reset values immediately.
